// File: rtl/audio_fir_engine.sv
// audio_fir_engine: time-multiplexed multi-channel FIR with one shared multiplier.
// Sits between the codec readdata (all channels packed) and codec writedata.
// Ports:
//   CLOCK_50, reset_n        clock, synchronous active-low reset
//   in_valid/in_ready/in_data   packed input frame handshake (ch k at [k*DW +: DW])
//   out_valid/out_ready/out_data filtered output frame handshake, same packing
//   bypass                   pass the accepted frame straight through
//   coef_we/coef_addr/coef_data  runtime coefficient load (IDLE only)
//   clear_hist               zero history and overflow (IDLE only)
//   busy                     engine not in IDLE
//   overflow                 sticky saturation flag
module audio_fir_engine #(
   parameter int unsigned DW    = 24,
   parameter int unsigned CW    = 16,
   parameter int unsigned NTAPS = 16,
   parameter int unsigned NCH   = 2,
   parameter int unsigned FRAC  = 15
) (
   input  logic                      CLOCK_50,
   input  logic                      reset_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NCH*DW-1:0]         in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NCH*DW-1:0]         out_data,
   input  logic                      bypass,
   input  logic                      coef_we,
   input  logic [$clog2(NTAPS)-1:0]  coef_addr,
   input  logic signed [CW-1:0]      coef_data,
   input  logic                      clear_hist,
   output logic                      busy,
   output logic                      overflow
);

   localparam int unsigned TW  = $clog2(NTAPS);
   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
   // Coefficients are stored one bit wider than CW so the reset value 1<<FRAC
   // stays a true +1.0 (in CW bits it would alias to -1.0).
   localparam int unsigned KW  = CW + 1;
   localparam int unsigned PW  = KW + DW;
   localparam int unsigned AW  = DW + CW + TW;

   localparam logic signed [AW:0]   RND      = (AW+1)'(64'sd1 <<< (FRAC - 1));
   localparam logic signed [AW:0]   SAT_MAX  = (AW+1)'((64'sd1 <<< (DW - 1)) - 64'sd1);
   localparam logic signed [AW:0]   SAT_MIN  = (AW+1)'(-(64'sd1 <<< (DW - 1)));
   localparam logic signed [KW-1:0] COEF_ONE = KW'(64'sd1 <<< FRAC);

   typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

   state_t               state_q, state_d;
   logic signed [KW-1:0] coef_q [NTAPS];
   logic signed [DW-1:0] hist_q [NCH][NTAPS];
   logic [TW-1:0]        wp_q, wp_inc_c, tap_q, rd_idx_c;
   logic [TW:0]          rd_diff_c;
   logic [CHW-1:0]       ch_q, prod_ch_q;
   logic signed [PW-1:0] prod_c, prod_q;
   logic                 prod_vld_q, prod_first_q, prod_last_q;
   logic signed [AW-1:0] acc_q, acc_base_c, acc_sum_c;
   logic signed [AW:0]   acc_rnd_c, y_wide_c;
   logic [DW-1:0]        y_c;
   logic                 sat_c;
   logic                 idle_c, accept_c, last_issue_c;

   assign idle_c       = (state_q == IDLE);
   assign accept_c     = in_valid && in_ready;
   assign last_issue_c = (tap_q == TW'(NTAPS - 1)) && (ch_q == CHW'(NCH - 1));

   // Circular-buffer addressing: wp points at the newest sample x[n].
   always_comb begin
      wp_inc_c  = (wp_q == TW'(NTAPS - 1)) ? '0 : wp_q + TW'(1);
      rd_diff_c = {1'b0, wp_q} - {1'b0, tap_q};
      rd_idx_c  = rd_diff_c[TW] ? TW'(rd_diff_c + (TW+1)'(NTAPS)) : rd_diff_c[TW-1:0];
      prod_c    = PW'(coef_q[tap_q]) * PW'(hist_q[ch_q][rd_idx_c]);
   end

   // Accumulate, round half up, saturate.
   always_comb begin
      acc_base_c = prod_first_q ? '0 : acc_q;
      acc_sum_c  = acc_base_c + AW'(prod_q);
      acc_rnd_c  = (AW+1)'(acc_sum_c) + RND;
      y_wide_c   = acc_rnd_c >>> FRAC;
      sat_c      = 1'b0;
      y_c        = y_wide_c[DW-1:0];
      if (y_wide_c > SAT_MAX) begin
         y_c   = SAT_MAX[DW-1:0];
         sat_c = 1'b1;
      end else if (y_wide_c < SAT_MIN) begin
         y_c   = SAT_MIN[DW-1:0];
         sat_c = 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = bypass ? OUT : MAC;
         MAC:     if (last_issue_c) state_d = FLUSH;
         FLUSH:   state_d = OUT;
         OUT:     if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Registered handshake/status outputs, derived from the next state.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         in_ready  <= (state_d == IDLE);
         out_valid <= (state_d == OUT);
         busy      <= (state_d != IDLE);
      end
   end

   // Datapath: coefficients, history, MAC pipeline, result write-back.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         for (int k = 0; k < NTAPS; k++) coef_q[k] <= (k == 0) ? COEF_ONE : '0;
         for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) hist_q[c][k] <= '0;
         wp_q         <= '0;
         tap_q        <= '0;
         ch_q         <= '0;
         prod_q       <= '0;
         prod_vld_q   <= 1'b0;
         prod_first_q <= 1'b0;
         prod_last_q  <= 1'b0;
         prod_ch_q    <= '0;
         acc_q        <= '0;
         out_data     <= '0;
         overflow     <= 1'b0;
      end else begin
         if (idle_c && coef_we) coef_q[coef_addr] <= KW'(coef_data);

         // Clear first so a same-cycle accept lands on zeroed history.
         if (idle_c && clear_hist) begin
            for (int c = 0; c < NCH; c++)
               for (int k = 0; k < NTAPS; k++) hist_q[c][k] <= '0;
            overflow <= 1'b0;
         end

         if (idle_c && accept_c) begin
            wp_q <= wp_inc_c;
            for (int c = 0; c < NCH; c++) hist_q[c][wp_inc_c] <= in_data[c*DW +: DW];
            if (bypass) out_data <= in_data;
         end

         // Tap inner, channel outer.
         if (state_q == MAC) begin
            if (tap_q == TW'(NTAPS - 1)) begin
               tap_q <= '0;
               ch_q  <= (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);
            end else begin
               tap_q <= tap_q + TW'(1);
            end
         end

         prod_q       <= prod_c;
         prod_vld_q   <= (state_q == MAC);
         prod_first_q <= (tap_q == '0);
         prod_last_q  <= (tap_q == TW'(NTAPS - 1));
         prod_ch_q    <= ch_q;

         if (prod_vld_q) begin
            acc_q <= acc_sum_c;
            if (prod_last_q) begin
               for (int c = 0; c < NCH; c++)
                  if (prod_ch_q == CHW'(c)) out_data[c*DW +: DW] <= y_c;
               if (sat_c) overflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_audio_fir_engine.sv
// Self-checking bench for audio_fir_engine with a behavioural FIR model.
module tb_audio_fir_engine;

   localparam int DW    = 24;
   localparam int CW    = 16;
   localparam int NTAPS = 16;
   localparam int NCH   = 2;
   localparam int FRAC  = 15;
   localparam int TW    = $clog2(NTAPS);
   localparam int LAT_F = NCH*NTAPS + 2;

   logic              CLOCK_50 = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [NCH*DW-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [NCH*DW-1:0] out_data;
   logic              bypass = 1'b0;
   logic              coef_we = 1'b0;
   logic [TW-1:0]     coef_addr = '0;
   logic [CW-1:0]     coef_data = '0;
   logic              clear_hist = 1'b0;
   logic              busy;
   logic              overflow;

   int total = 0;
   int bad   = 0;

   audio_fir_engine #(.DW(DW), .CW(CW), .NTAPS(NTAPS), .NCH(NCH), .FRAC(FRAC)) dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .bypass(bypass), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .clear_hist(clear_hist), .busy(busy), .overflow(overflow)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Reference model: coefficient list, per-channel delay line (index k = x[n-k]), sticky flag.
   longint m_coef [NTAPS];
   longint m_hist [NCH][NTAPS];
   bit     m_ovf;

   task automatic model_reset();
      for (int k = 0; k < NTAPS; k++) m_coef[k] = (k == 0) ? (64'sd1 <<< FRAC) : 0;
      for (int c = 0; c < NCH; c++)
         for (int k = 0; k < NTAPS; k++) m_hist[c][k] = 0;
      m_ovf = 0;
   endtask

   task automatic model_frame(input logic [NCH*DW-1:0] din, input bit byp, input bit clr,
                              input bit cw, input int caddr, input logic [CW-1:0] cdata,
                              output logic [NCH*DW-1:0] exp);
      logic signed [CW-1:0] cs;
      logic signed [DW-1:0] ds;
      longint acc, y;
      longint ymax, ymin;
      ymax = (64'sd1 <<< (DW-1)) - 1;
      ymin = -(64'sd1 <<< (DW-1));
      if (cw) begin
         cs = cdata;
         m_coef[caddr] = longint'(cs);
      end
      if (clr) begin
         for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) m_hist[c][k] = 0;
         m_ovf = 0;
      end
      for (int c = 0; c < NCH; c++) begin
         for (int k = NTAPS-1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
         ds = din[c*DW +: DW];
         m_hist[c][0] = longint'(ds);
      end
      exp = din;
      if (!byp) begin
         for (int c = 0; c < NCH; c++) begin
            acc = 0;
            for (int k = 0; k < NTAPS; k++) acc += m_coef[k] * m_hist[c][k];
            y = (acc + (64'sd1 <<< (FRAC-1))) >>> FRAC;
            if (y > ymax) begin y = ymax; m_ovf = 1; end
            if (y < ymin) begin y = ymin; m_ovf = 1; end
            exp[c*DW +: DW] = y[DW-1:0];
         end
      end
   endtask

   task automatic write_coef(input int addr, input logic [CW-1:0] data);
      logic signed [CW-1:0] cs;
      @(negedge CLOCK_50);
      coef_we = 1'b1; coef_addr = TW'(addr); coef_data = data;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      coef_we = 1'b0;
      cs = data;
      m_coef[addr] = longint'(cs);
   endtask

   task automatic pulse_clear();
      @(negedge CLOCK_50);
      clear_hist = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      clear_hist = 1'b0;
      for (int c = 0; c < NCH; c++)
         for (int k = 0; k < NTAPS; k++) m_hist[c][k] = 0;
      m_ovf = 0;
   endtask

   // Offer one frame, wait (bounded) for out_valid, optionally stall, complete handshake.
   // lat counts edges from the accept edge to the edge that first sees out_valid.
   task automatic run_frame(input logic [NCH*DW-1:0] din, input bit byp, input bit clr,
                            input bit cw, input int caddr, input logic [CW-1:0] cdata,
                            input int stall, output logic [NCH*DW-1:0] obs, output int lat);
      int n;
      @(negedge CLOCK_50);
      in_data = din; bypass = byp; in_valid = 1'b1;
      clear_hist = clr; coef_we = cw; coef_addr = TW'(caddr); coef_data = cdata;
      out_ready = (stall == 0);
      n = 0;
      while (!in_ready && n < 100) begin @(negedge CLOCK_50); n++; end
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      in_valid = 1'b0; bypass = 1'b0; clear_hist = 1'b0; coef_we = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin @(negedge CLOCK_50); lat++; end
      obs = out_data;
      repeat (stall) @(negedge CLOCK_50);
      out_ready = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      model_reset();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
   endtask

   task automatic test_identity();
      logic [NCH*DW-1:0] din, exp, obs;
      int lat;
      din = '0;
      din[0 +: DW]  = 24'h001234;
      din[DW +: DW] = 24'hFFF000;
      model_frame(din, 0, 0, 0, 0, '0, exp);
      run_frame(din, 0, 0, 0, 0, '0, 0, obs, lat);
      total++; if (lat !== LAT_F) begin bad++; $display("FAIL identity_latency: got %0d want %0d", lat, LAT_F); end
      total++; if (obs !== exp) begin bad++; $display("FAIL identity_data: got %h want %h", obs, exp); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL identity_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_moving_avg();
      logic [NCH*DW-1:0] din, exp, obs;
      int lat;
      for (int k = 0; k < NTAPS; k++) write_coef(k, (k < 4) ? 16'h2000 : 16'h0000);
      pulse_clear();
      for (int f = 0; f < 20; f++) begin
         din = '0;
         if (f < 4) din[0 +: DW] = 24'd400;
         din[DW +: DW] = DW'($urandom_range(0, 2000));
         model_frame(din, 0, 0, 0, 0, '0, exp);
         run_frame(din, 0, 0, 0, 0, '0, 0, obs, lat);
         total++; if (obs !== exp) begin bad++; $display("FAIL avg_frame%0d: got %h want %h", f, obs, exp); end
         total++; if (lat !== LAT_F) begin bad++; $display("FAIL avg_latency%0d: got %0d want %0d", f, lat, LAT_F); end
      end
   endtask

   task automatic test_saturation();
      logic [NCH*DW-1:0] din, exp, obs;
      int lat;
      write_coef(0, 16'h7FFF);
      write_coef(1, 16'h7FFF);
      write_coef(2, 16'h0000);
      write_coef(3, 16'h0000);
      din = '0;
      din[0 +: DW] = 24'h7FFFFF;
      for (int f = 0; f < 2; f++) begin
         model_frame(din, 0, 0, 0, 0, '0, exp);
         run_frame(din, 0, 0, 0, 0, '0, 0, obs, lat);
         total++; if (obs !== exp) begin bad++; $display("FAIL sat_frame%0d: got %h want %h", f, obs, exp); end
      end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_overflow_set: got %b want 1", overflow); end
      din[0 +: DW] = 24'd5;
      model_frame(din, 0, 0, 0, 0, '0, exp);
      run_frame(din, 0, 0, 0, 0, '0, 0, obs, lat);
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL sat_overflow_sticky: got %b want %b", overflow, m_ovf); end
      pulse_clear();
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clear_overflow: got %b want 0", overflow); end
      din[0 +: DW] = 24'h7FFFFF;
      model_frame(din, 0, 0, 0, 0, '0, exp);
      run_frame(din, 0, 0, 0, 0, '0, 0, obs, lat);
      total++; if (obs !== exp) begin bad++; $display("FAIL clear_single_tap: got %h want %h", obs, exp); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL clear_overflow_after: got %b want %b", overflow, m_ovf); end
   endtask

   task automatic test_backpressure();
      logic [NCH*DW-1:0] din, exp, obs, held;
      int lat;
      for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'($urandom_range(0, 100000));
      model_frame(din, 0, 0, 0, 0, '0, exp);
      @(negedge CLOCK_50);
      out_ready = 1'b0; in_data = din; in_valid = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin @(negedge CLOCK_50); lat++; end
      held = out_data;
      total++; if (lat !== LAT_F) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT_F); end
      total++; if (held !== exp) begin bad++; $display("FAIL bp_data: got %h want %h", held, exp); end
      in_data = ~din; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLOCK_50);
         total++; if (out_data !== held) begin bad++; $display("FAIL bp_hold%0d: got %h want %h", i, out_data, held); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid%0d: got %b want 1", i, out_valid); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy%0d: got %b want 1", i, busy); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
      din = '0;
      din[0 +: DW] = 24'd1000;
      model_frame(din, 0, 0, 0, 0, '0, exp);
      run_frame(din, 0, 0, 0, 0, '0, 0, obs, lat);
      total++; if (obs !== exp) begin bad++; $display("FAIL bp_not_accepted: got %h want %h", obs, exp); end
   endtask

   task automatic test_bypass();
      logic [NCH*DW-1:0] din, exp, obs;
      int lat;
      for (int k = 0; k < NTAPS; k++) write_coef(k, (k == 1) ? 16'h4000 : 16'h0000);
      din = '0;
      din[0 +: DW]  = DW'($urandom);
      din[DW +: DW] = 24'h800000;
      model_frame(din, 1, 0, 0, 0, '0, exp);
      run_frame(din, 1, 0, 0, 0, '0, 0, obs, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL bypass_latency: got %0d want 1", lat); end
      total++; if (obs !== din) begin bad++; $display("FAIL bypass_data: got %h want %h", obs, din); end
      din = '0;
      din[DW +: DW] = 24'd77;
      model_frame(din, 0, 0, 0, 0, '0, exp);
      run_frame(din, 0, 0, 0, 0, '0, 0, obs, lat);
      total++; if (obs !== exp) begin bad++; $display("FAIL bypass_history: got %h want %h", obs, exp); end
      total++; if (obs[DW +: DW] !== 24'hC00000) begin bad++; $display("FAIL bypass_history_ch1: got %h want c00000", obs[DW +: DW]); end
   endtask

   task automatic test_coef_we_busy();
      logic [NCH*DW-1:0] din, exp, obs;
      int lat;
      for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'($urandom_range(0, 500000));
      model_frame(din, 0, 0, 0, 0, '0, exp);
      fork
         run_frame(din, 0, 0, 0, 0, '0, 0, obs, lat);
         begin
            repeat (5) @(negedge CLOCK_50);
            coef_we = 1'b1; coef_addr = TW'(1); coef_data = 16'h7123;
            repeat (3) @(negedge CLOCK_50);
            coef_we = 1'b0;
         end
      join
      total++; if (obs !== exp) begin bad++; $display("FAIL coef_we_busy: got %h want %h", obs, exp); end
      // Write coincident with accept must be used by that same frame.
      model_frame(din, 0, 0, 1, 0, 16'h2000, exp);
      run_frame(din, 0, 0, 1, 0, 16'h2000, 0, obs, lat);
      total++; if (obs !== exp) begin bad++; $display("FAIL coef_we_accept: got %h want %h", obs, exp); end
      // Clear coincident with accept: new frame sees only itself.
      model_frame(din, 0, 1, 0, 0, '0, exp);
      run_frame(din, 0, 1, 0, 0, '0, 0, obs, lat);
      total++; if (obs !== exp) begin bad++; $display("FAIL clear_accept: got %h want %h", obs, exp); end
   endtask

   task automatic test_random();
      logic [NCH*DW-1:0] din, exp, obs;
      logic [CW-1:0] cdata;
      int lat, caddr, stall;
      bit byp, clr, cw;
      for (int f = 0; f < 24; f++) begin
         for (int c = 0; c < NCH; c++)
            din[c*DW +: DW] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 4095));
         byp   = ($urandom_range(0, 4) == 0);
         clr   = ($urandom_range(0, 7) == 0);
         cw    = ($urandom_range(0, 2) == 0);
         caddr = $urandom_range(0, NTAPS-1);
         cdata = CW'($urandom);
         stall = $urandom_range(0, 3);
         model_frame(din, byp, clr, cw, caddr, cdata, exp);
         run_frame(din, byp, clr, cw, caddr, cdata, stall, obs, lat);
         total++; if (obs !== exp) begin bad++; $display("FAIL rand_data%0d: got %h want %h", f, obs, exp); end
         total++; if (lat !== (byp ? 1 : LAT_F)) begin bad++; $display("FAIL rand_latency%0d: got %0d want %0d", f, lat, byp ? 1 : LAT_F); end
         total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_overflow%0d: got %b want %b", f, overflow, m_ovf); end
      end
   endtask

   task automatic test_reset_mid_mac();
      logic [NCH*DW-1:0] din, exp, obs;
      int lat;
      for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'($urandom);
      @(negedge CLOCK_50);
      in_data = din; in_valid = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      in_valid = 1'b0;
      repeat (10) @(negedge CLOCK_50);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midmac_busy: got %b want 1", busy); end
      reset_n = 1'b0;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      model_reset();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midmac_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midmac_out_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midmac_busy_clr: got %b want 0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midmac_overflow: got %b want 0", overflow); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL midmac_out_data: got %h want 0", out_data); end
      for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'($urandom);
      model_frame(din, 0, 0, 0, 0, '0, exp);
      run_frame(din, 0, 0, 0, 0, '0, 0, obs, lat);
      total++; if (obs !== din) begin bad++; $display("FAIL midmac_identity: got %h want %h", obs, din); end
      total++; if (obs !== exp) begin bad++; $display("FAIL midmac_model: got %h want %h", obs, exp); end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_moving_avg();
      test_saturation();
      test_backpressure();
      test_bypass();
      test_coef_we_busy();
      test_random();
      test_reset_mid_mac();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/audio_fir_engine.md
Name: audio_fir_engine

Overview:
- Parametrised, time-multiplexed multi-channel FIR filter for the audio codec sample path, one shared multiplier.
- Sits between codec readdata (all channels packed) and codec writedata.
- Adds over the per-channel fixed filters: runtime-loadable coefficients, valid/ready handshake with backpressure, bypass mode, saturation with a sticky overflow flag, and history clear.

Parameters:
DW, 24, signed sample width per channel
CW, 16, signed coefficient width
NTAPS, 16, taps per channel (>=2)
NCH, 2, channel count (ch0 = left, occupies LSBs)
FRAC, 15, coefficient fractional bits (Q1.FRAC)

Ports:
CLOCK_50  in  1  system clock; all logic on the rising edge
reset_n  in  1  synchronous reset, active-low
in_valid  in  1  input frame valid
in_ready  out  1  engine can accept a frame
in_data  in  NCH*DW  packed signed samples, ch k at [k*DW +: DW]
out_valid  out  1  output frame valid
out_ready  in  1  consumer accepts the output frame
out_data  out  NCH*DW  packed filtered samples, same packing as in_data
bypass  in  1  1 = pass samples through unfiltered
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NTAPS)  tap index
coef_data  in  CW  signed coefficient
clear_hist  in  1  zero all history and overflow
busy  out  1  state != IDLE
overflow  out  1  sticky; set when any output saturates

Behaviour:
- Reset (reset_n==0 at an edge, any state, including mid-MAC): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, overflow=0, all history=0, coef[0]=1<<FRAC, coef[1..NTAPS-1]=0 (identity filter), tap and channel counters=0.
- History: per-channel circular buffer of NTAPS samples in flops, with a shared write pointer that advances by 1 mod NTAPS per accepted frame. x[n-k] is read at (wp-k) mod NTAPS, with wrap-around.
- FSM states: IDLE, MAC, FLUSH, OUT.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&&in_ready: write all channels into history and latch bypass.
  - If bypass, go to OUT with out_data=in_data (latency 1).
  - Otherwise go to MAC.
- MAC:
  - One product coef[k]*x_ch[n-k] is issued per cycle: k from 0 to NTAPS-1 inner, ch from 0 to NCH-1 outer. NCH*NTAPS cycles total.
  - The product is registered (1-stage pipeline) and then added into the accumulator.
  - The accumulator is cleared at the start of each channel.
- FLUSH (1 cycle): the final product is added. Each channel result is written into the out_data slot when that channel finishes.
- Result arithmetic:
  - Accumulator width = DW+CW+clog2(NTAPS), signed.
  - y = (acc + 2^(FRAC-1)) >>> FRAC (round half up).
  - Saturate y to [-2^(DW-1), 2^(DW-1)-1]. On saturation, set overflow.
- Latency: the accept edge is cycle 0. out_valid rises at cycle NCH*NTAPS+2 (34 with defaults). For bypass, it rises at cycle 1.
- OUT:
  - out_valid=1; out_data is held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE; in_ready=1 on the next cycle.
  - No new frame is accepted while not IDLE (in_ready=0). Throughput is therefore 1 frame per NCH*NTAPS+3 cycles when out_ready=1.
- Coefficients:
  - coef_we is honoured only in IDLE. When busy, it is ignored with no side effect.
  - A write in the same cycle as a frame accept is applied and is visible to that frame's MAC.
- clear_hist:
  - Honoured only in IDLE: all history=0 and overflow=0 next cycle; coefficients and pointer are untouched.
  - If clear_hist and an accept occur in the same cycle, clear is applied first and the new samples are written, so the new frame sees zero history.
  - Ignored when busy.
- out_data changes only on channel completion or a bypass accept. It keeps its last value in IDLE.

Test Plan:
- Reset, then default coefs; send in_data ch0=0x001234, ch1=0xFFF000 -> out_valid at cycle 34, out_data ch0=0x001234, ch1=0xFFF000; overflow=0.
- Load 4 taps of 0x2000 (0.25), rest 0; send four frames of ch0=400 -> outputs 100, 200, 300, 400. Then send 0 -> output 300 (history wrap verified with NTAPS=16 over 20 frames).
- coef[0]=0x7FFF, coef[1]=0x7FFF; send ch0=0x7FFFFF twice -> second output 0x7FFFFF saturated, overflow=1 stays high. clear_hist in IDLE -> overflow=0 and next output = single-tap result.
- Hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, in_valid frames not accepted. Release -> in_ready=1 next cycle.
- bypass=1, send ch1=0x800000 -> out_valid at cycle 1 with identical data; the following filtered frame still sees this sample in history.
- coef_we during MAC ignored (result unchanged). reset_n=0 mid-MAC -> next cycle IDLE, out_valid=0, history zero, coefficients back to identity.
